sevenseg_scan: RTL and testbench

//  Time-multiplexed driver for an NDIGITS common-anode/cathode seven-segment display.

---
 rtl/sevenseg_pkg.sv | 17 +
 rtl/sevenseg_scan_ctr.sv | 50 +++++
 rtl/sevenseg_scan.sv | 122 ++++++++++++
 tb/tb_sevenseg_scan.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants: hex to abc_defg table (active-high, bit 6 = a).
// Pure constants and a lookup function; no state, no flow control.
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Packed table: element [n] is the pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h73, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctr.sv
// Slot counter and digit index for the display scan; state updates every enabled cycle.
// en_i=0 freezes both; in_blank_o flags the anti-ghost gap at the start of each slot.
module sevenseg_scan_ctr #(
  parameter int NDIGITS   = 4,
  parameter int DIVIDE    = 1024,
  parameter int BLANK_CYC = 16,
  localparam int CW = $clog2(DIVIDE),
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  output logic [IW-1:0] idx_o,
  output logic          in_blank_o,
  output logic          slot_wrap_o
);

  localparam logic [CW-1:0] LAST_CNT = CW'(DIVIDE - 1);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYC);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  assign slot_wrap_o = en_i && (cnt_q == LAST_CNT);
  assign in_blank_o  = (cnt_q < BLANK_C);
  assign idx_o       = idx_q;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (slot_wrap_o) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment driver: shadow-latched hex word, LZ blanking, anti-ghost gap.
// Outputs registered, 1-cycle latency from counter/shadow state; no backpressure (en freezes scan).
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS    = 4,
  parameter int DIVIDE     = 1024,
  parameter int BLANK_CYC  = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   load,
  input  logic                   lzb,
  input  logic                   en,
  output logic [6:0]             segments,
  output logic                   dp,
  output logic [NDIGITS-1:0]     anode
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [6:0]         SEG_POL = {7{ACTIVE_LOW}};
  localparam logic [NDIGITS-1:0] AN_POL  = {NDIGITS{ACTIVE_LOW}};

  logic [4*NDIGITS-1:0] data_q;
  logic [NDIGITS-1:0]   dpm_q;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [NDIGITS-1:0]   an_q, an_d;

  logic [IW-1:0]        idx;
  logic                 in_blank;
  logic                 slot_wrap;

  sevenseg_scan_ctr #(
    .NDIGITS  (NDIGITS),
    .DIVIDE   (DIVIDE),
    .BLANK_CYC(BLANK_CYC)
  ) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en),
    .idx_o      (idx),
    .in_blank_o (in_blank),
    .slot_wrap_o(slot_wrap)
  );

  // nz_above[i] = any nonzero nibble at position i or higher (prefix-OR from MSB).
  logic [NDIGITS-1:0] nz_above;
  logic               nz_carry;

  always_comb begin
    nz_above = '0;
    nz_carry = 1'b0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      nz_carry    = nz_carry | (|data_q[4*i +: 4]);
      nz_above[i] = nz_carry;
    end
  end

  logic [3:0]         cur_nib;
  logic               cur_dp;
  logic               cur_blank;
  logic [NDIGITS-1:0] cur_onehot;

  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib       = data_q[4*i +: 4];
        cur_dp        = dpm_q[i];
        cur_blank     = lzb && (i != 0) && !nz_above[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_d = SEG_OFF ^ SEG_POL;
    dp_d  = ACTIVE_LOW;
    an_d  = AN_POL;
    if (en && !in_blank) begin
      seg_d = (cur_blank ? SEG_OFF : hex2seg(cur_nib)) ^ SEG_POL;
      dp_d  = cur_dp ^ ACTIVE_LOW;
      an_d  = cur_onehot ^ AN_POL;
    end
  end

  // Shadow load is independent of the scan, so a load on the wrap edge is seen by the new digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      dpm_q  <= '0;
    end else if (load) begin
      data_q <= data;
      dpm_q  <= dp_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_OFF ^ SEG_POL;
      dp_q  <= ACTIVE_LOW;
      an_q  <= AN_POL;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign segments = seg_q;
  assign dp       = dp_q;
  assign anode    = an_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench: a behavioural scan model pushes expected outputs per edge, both polarities checked.
module tb_sevenseg_scan;

  localparam int ND  = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic        en = 1'b0;

  logic [6:0]  seg_l, seg_h;
  logic        dp_l, dp_h;
  logic [3:0]  an_l, an_h;

  always #5 clk = ~clk;

  sevenseg_scan #(.NDIGITS(ND), .DIVIDE(DIV), .BLANK_CYC(BLK), .ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .load(load), .lzb(lzb), .en(en),
    .segments(seg_l), .dp(dp_l), .anode(an_l)
  );

  sevenseg_scan #(.NDIGITS(ND), .DIVIDE(DIV), .BLANK_CYC(BLK), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .load(load), .lzb(lzb), .en(en),
    .segments(seg_h), .dp(dp_h), .anode(an_h)
  );

  logic [6:0] seg_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int          m_cnt, m_idx;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;
  exp_t        exp_q [$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_tick = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s tick=%0d: got %0h expected %0h", tag, n_tick, obs, exp);
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    if (en && m_cnt >= BLK) begin
      e.an = 4'b0001 << m_idx;
      e.dp = m_dp[m_idx];
      if (!(lzb && m_idx > 0 && (m_sh >> (4 * m_idx)) == 16'h0))
        e.seg = seg_tbl[m_sh[4*m_idx +: 4]];
    end
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    logic [6:0] inv_seg;
    logic       inv_dp;
    logic [3:0] inv_an;
    exp_q.push_back(model_out());
    if (load) begin
      m_sh = data;
      m_dp = dp_in;
    end
    if (en) begin
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    n_tick++;
    e = exp_q.pop_front();
    inv_seg = ~e.seg;
    inv_dp  = ~e.dp;
    inv_an  = ~e.an;
    check("seg_hi", 32'(seg_h), 32'(e.seg));
    check("dp_hi",  32'(dp_h),  32'(e.dp));
    check("an_hi",  32'(an_h),  32'(e.an));
    check("seg_lo", 32'(seg_l), 32'(inv_seg));
    check("dp_lo",  32'(dp_l),  32'(inv_dp));
    check("an_lo",  32'(an_l),  32'(inv_an));
  endtask

  task automatic check_inactive(input string tag);
    check({tag, "_seg_lo"}, 32'(seg_l), 32'h7F);
    check({tag, "_dp_lo"},  32'(dp_l),  32'h1);
    check({tag, "_an_lo"},  32'(an_l),  32'hF);
    check({tag, "_seg_hi"}, 32'(seg_h), 32'h0);
    check({tag, "_dp_hi"},  32'(dp_h),  32'h0);
    check({tag, "_an_hi"},  32'(an_h),  32'h0);
  endtask

  // Called 1 time unit after a rising edge; reset asserts mid-cycle.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check_inactive("rst_now");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_inactive("rst_hold");
    end
    m_cnt = 0;
    m_idx = 0;
    m_sh  = '0;
    m_dp  = '0;
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic run_to(input int cnt, input int idx, input string tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 64 && !hit; k++) begin
      if (m_cnt == cnt && (idx < 0 || m_idx == idx)) hit = 1'b1;
      else tick();
    end
    check(tag, 32'(hit), 32'h1);
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] p);
    data  = d;
    dp_in = p;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  initial begin
    m_cnt = 0;
    m_idx = 0;
    m_sh  = '0;
    m_dp  = '0;
    #1;
    reset = 1'b1;
    #1;
    check_inactive("rst_init");
    @(posedge clk);
    #1;
    m_cnt = 0;
    reset = 1'b0;

    // Scan of 1234: digits 0..3 show 4,3,2,1
    en = 1'b1;
    load_word(16'h1234, 4'h0);
    repeat (40) tick();

    run_to(4, -1, "reach_midslot");
    do_reset();
    en = 1'b1;
    repeat (10) tick();

    lzb = 1'b1;
    load_word(16'h0050, 4'h0);
    repeat (33) tick();
    load_word(16'h0000, 4'h0);
    repeat (33) tick();

    load_word(16'h0000, 4'b0100);
    repeat (33) tick();

    lzb = 1'b0;
    load_word(16'h1234, 4'h0);
    run_to(5, 1, "reach_c5d1");
    en = 1'b0;
    repeat (20) tick();
    en = 1'b1;
    repeat (12) tick();

    run_to(7, -1, "reach_wrap");
    load_word(16'hABCD, 4'h0);
    repeat (12) tick();

    for (int k = 0; k < 200; k++) begin
      en    = ($urandom_range(0, 7) != 0);
      lzb   = 1'($urandom_range(0, 1));
      load  = ($urandom_range(0, 5) == 0);
      data  = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in = 4'($urandom_range(0, 15));
      tick();
    end
    load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
